control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Sequencing and execute core of the RV32I multi-cycle CPU. It decodes opcode/f3/f7 into datapath-select and strobe signals, runs the fetch/execute FSM, and contains the 32-bit ALU and the program counter register. It sits between the decoder/register file and the instruction and data memory units.

Parameters:
XLEN, 32, datapath width.
RESET_PC, 32'h0, value loaded into the program counter on reset.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
opcode  in  7  ir[6:0]
f3  in  3  funct3
f7  in  7  funct7
stall  in  1  high while the instruction or data memory unit is not ready
debug_wait  in  1  high holds the core in FETCH
alu_in_a  in  32  ALU operand A (rs1 or current PC, muxed outside using data_path.alu_in_a)
alu_in_b  in  32  ALU operand B (rs2 or immediate, muxed outside using data_path.alu_in_b)
imm  in  32  decoded immediate (branch offset)
instruction_len  in  32  byte length of the current instruction (4)
data_path  out  4  packed {alu_in_a_sel(1): REG=0/PC=1, alu_in_b_sel(1): REG=0/IMM=1, dest_reg_from(2): NONE=0/ALU=1/MEM=2/PC=3}
alu_mode  out  4  alu_mode_t
invert_logic_result  out  1  inverts the branch condition
fetch_next_instruction, load_ir, increment_pc, load_pc, dbus_we, dbus_re, load_rd, branching  out  1 each  strobes
alu_out  out  32  ALU result, combinational
pc_out  out  32  program counter value

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to FETCH; pc_out is RESET_PC.
- Strobes are Moore/Mealy combinational from state and inputs. Any strobe not listed for a state is 0.
- FETCH:
  - Asserts fetch_next_instruction and load_ir.
  - Goes to EXECUTE when !stall && !debug_wait; otherwise stays in FETCH.
- EXECUTE (decode by opcode):
  - OP: A=REG, B=REG, dest=ALU.
  - OP-IMM: A=REG, B=IMM, dest=ALU.
  - LUI: A=REG (decoder forces rs1=0), B=IMM, mode ADD, dest=ALU.
  - AUIPC: A=PC, B=IMM, ADD, dest=ALU.
  - LOAD: A=REG, B=IMM, ADD, dbus_re=1, dest=MEM.
  - STORE: A=REG, B=IMM, ADD, dbus_we=1, dest=NONE.
  - BRANCH: A=REG, B=REG, branching=1, dest=NONE. BEQ: SUB, invert=1. BNE: SUB, invert=0. BLT: SLT, 0. BGE: SLT, 1. BLTU: SLTU, 0. BGEU: SLTU, 1.
  - JAL: A=PC, B=IMM, ADD, increment_pc=1, then go to JUMP.
  - JALR: A=REG, B=IMM, ADD, increment_pc=1, then go to JUMP.
  - Unknown opcode: executes as a NOP.
  - Completion (non-jump) occurs in the first EXECUTE cycle with stall=0. In that cycle assert load_rd (if dest≠NONE) and increment_pc, then go to FETCH.
  - While stall=1: hold EXECUTE with dbus_re/dbus_we kept asserted, and assert no load_rd/increment_pc.
- JUMP:
  - Operand selects are unchanged.
  - Asserts load_rd with dest=PC (rd receives the already-incremented pc_out), and load_pc.
  - For JALR the loaded value has bit0 cleared.
  - Goes to FETCH.
- ALU function decode for OP/OP-IMM uses f3: 000 ADD (SUB if OP && f7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if f7[5]), 110 OR, 111 AND.
- ALU arithmetic:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use in_b[4:0]; SRA is arithmetic.
  - SLT is signed and SLTU unsigned; both give result 0 or 1.
- Branch step: take = (alu_out≠0) XOR invert_logic_result. pc_step = imm if (take && branching), else instruction_len.
- Counter, at posedge:
  - load_pc has priority: pc <= alu_out (JALR: & ~1).
  - else increment_pc: pc <= pc + pc_step (wraps).
  - else pc holds.
- Reset mid-instruction aborts the instruction; no strobe is asserted while rst=0.
- A simulation-only task set_execute forces the FSM to EXECUTE.

Decomposition:
- Package Types holds:
  - alu_mode_t (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9)
  - data_path_map_t and its enums
  - opcode constants
  - uint32_t / int32_t
- Natural sub-module: alu (in_a, in_b, mode → out). The FSM, decode and counter stay in control_unit.

Test Plan:
- Reset with rst=0 → pc_out=0, FETCH, fetch_next_instruction=1, load_ir=1. Release with stall=0 → EXECUTE next cycle.
- ADDI (opcode 0010011, f3=000), A=5, B=-7 → alu_out=0xFFFFFFFE, load_rd=1, dest=ALU; pc advances 0→4.
- BEQ with A=B=9, imm=16, pc=8 → SUB, invert=1, branch taken, pc=24. With A≠B → pc=12.
- LOAD with stall high 3 cycles → dbus_re held for 4 cycles, load_rd only in the final cycle; pc increments once.
- JAL at pc=0x100, imm=0x20 → EXECUTE increments pc to 0x104; JUMP asserts load_rd with dest=PC (0x104) and sets pc=0x120.
- SRA with A=0x80000000, B=4 → 0xF8000000. SLTU with A=1, B=0xFFFFFFFF → 1. debug_wait=1 holds FETCH.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types for the RV32I multi-cycle control unit: ALU modes, datapath select map,
// opcode constants and FSM states.
package control_unit_pkg;

  typedef logic [31:0]        uint32_t;
  typedef logic signed [31:0] int32_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_mode_t;

  typedef enum logic {ASelReg = 1'b0, ASelPc = 1'b1} alu_in_a_sel_t;
  typedef enum logic {BSelReg = 1'b0, BSelImm = 1'b1} alu_in_b_sel_t;
  typedef enum logic [1:0] {
    DestNone = 2'd0,
    DestAlu  = 2'd1,
    DestMem  = 2'd2,
    DestPc   = 2'd3
  } dest_reg_from_t;

  typedef struct packed {
    alu_in_a_sel_t  alu_in_a;
    alu_in_b_sel_t  alu_in_b;
    dest_reg_from_t dest_reg_from;
  } data_path_map_t;

  typedef enum logic [1:0] {StFetch, StExecute, StJump} state_t;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;

  // f7[5] selects SUB only for register-register ops; it always selects SRA.
  function automatic alu_mode_t alu_func(input logic [2:0] f3, input logic f7_5,
                                         input logic is_op);
    alu_mode_t m;
    case (f3)
      3'b000:  m = (is_op && f7_5) ? AluSub : AluAdd;
      3'b001:  m = AluSll;
      3'b010:  m = AluSlt;
      3'b011:  m = AluSltu;
      3'b100:  m = AluXor;
      3'b101:  m = f7_5 ? AluSra : AluSrl;
      3'b110:  m = AluOr;
      default: m = AluAnd;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/control_unit_alu.sv
// 32-bit integer ALU; purely combinational.
module control_unit_alu
  import control_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  alu_mode_t       mode,
  output logic [XLEN-1:0] out
);

  logic [4:0] shamt;
  assign shamt = in_b[4:0];

  always_comb begin
    out = '0;
    case (mode)
      AluAdd:  out = in_a + in_b;
      AluSub:  out = in_a - in_b;
      AluSll:  out = in_a << shamt;
      AluSlt:  out = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      AluSltu: out = {{(XLEN-1){1'b0}}, in_a < in_b};
      AluXor:  out = in_a ^ in_b;
      AluSrl:  out = in_a >> shamt;
      AluSra:  out = $unsigned($signed(in_a) >>> shamt);
      AluOr:   out = in_a | in_b;
      AluAnd:  out = in_a & in_b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I multi-cycle sequencer: opcode decode, fetch/execute/jump FSM, ALU and program counter.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic            stall,
  input  logic            debug_wait,
  input  logic [XLEN-1:0] alu_in_a,
  input  logic [XLEN-1:0] alu_in_b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] instruction_len,
  output logic [3:0]      data_path,
  output logic [3:0]      alu_mode,
  output logic            invert_logic_result,
  output logic            fetch_next_instruction,
  output logic            load_ir,
  output logic            increment_pc,
  output logic            load_pc,
  output logic            dbus_we,
  output logic            dbus_re,
  output logic            load_rd,
  output logic            branching,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] pc_out
);

  state_t         state_q, state_d;
  logic [XLEN-1:0] pc_q;
  data_path_map_t dp_dec, dp_out;
  alu_mode_t      mode_dec;
  logic           inv_dec, is_branch, is_load, is_store, is_jump, is_jalr;
  logic           take;
  logic [XLEN-1:0] pc_step;

  logic unused_f7;
  assign unused_f7 = ^{f7[6], f7[4:0]};

  // Toggle handshake lets a testbench push the FSM into EXECUTE without a second driver.
  bit   force_req = 1'b0;
  logic force_ack_q;

  task automatic set_execute();
    force_req = ~force_req;
  endtask

  always_comb begin
    dp_dec    = '{alu_in_a: ASelReg, alu_in_b: BSelReg, dest_reg_from: DestNone};
    mode_dec  = AluAdd;
    inv_dec   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_jump   = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OpcodeOp: begin
        dp_dec.dest_reg_from = DestAlu;
        mode_dec             = alu_func(f3, f7[5], 1'b1);
      end
      OpcodeOpImm: begin
        dp_dec.alu_in_b      = BSelImm;
        dp_dec.dest_reg_from = DestAlu;
        mode_dec             = alu_func(f3, f7[5], 1'b0);
      end
      OpcodeLui: begin
        dp_dec.alu_in_b      = BSelImm;
        dp_dec.dest_reg_from = DestAlu;
      end
      OpcodeAuipc: begin
        dp_dec.alu_in_a      = ASelPc;
        dp_dec.alu_in_b      = BSelImm;
        dp_dec.dest_reg_from = DestAlu;
      end
      OpcodeLoad: begin
        dp_dec.alu_in_b      = BSelImm;
        dp_dec.dest_reg_from = DestMem;
        is_load              = 1'b1;
      end
      OpcodeStore: begin
        dp_dec.alu_in_b = BSelImm;
        is_store        = 1'b1;
      end
      OpcodeBranch: begin
        is_branch = 1'b1;
        case (f3)
          3'b000:  begin mode_dec = AluSub;  inv_dec = 1'b1; end
          3'b001:  begin mode_dec = AluSub;  inv_dec = 1'b0; end
          3'b100:  begin mode_dec = AluSlt;  inv_dec = 1'b0; end
          3'b101:  begin mode_dec = AluSlt;  inv_dec = 1'b1; end
          3'b110:  begin mode_dec = AluSltu; inv_dec = 1'b0; end
          3'b111:  begin mode_dec = AluSltu; inv_dec = 1'b1; end
          default: begin mode_dec = AluSub;  inv_dec = 1'b0; end
        endcase
      end
      OpcodeJal: begin
        dp_dec.alu_in_a = ASelPc;
        dp_dec.alu_in_b = BSelImm;
        is_jump         = 1'b1;
      end
      OpcodeJalr: begin
        dp_dec.alu_in_b = BSelImm;
        is_jump         = 1'b1;
        is_jalr         = 1'b1;
      end
      default: ;
    endcase
  end

  control_unit_alu #(.XLEN(XLEN)) u_alu (
    .in_a (alu_in_a),
    .in_b (alu_in_b),
    .mode (mode_dec),
    .out  (alu_out)
  );

  always_comb begin
    state_d                = state_q;
    dp_out                 = dp_dec;
    dp_out.dest_reg_from   = DestNone;
    fetch_next_instruction = 1'b0;
    load_ir                = 1'b0;
    increment_pc           = 1'b0;
    load_pc                = 1'b0;
    dbus_we                = 1'b0;
    dbus_re                = 1'b0;
    load_rd                = 1'b0;
    branching              = 1'b0;
    case (state_q)
      StFetch: begin
        fetch_next_instruction = 1'b1;
        load_ir                = 1'b1;
        if (!stall && !debug_wait) state_d = StExecute;
      end
      StExecute: begin
        if (!is_jump) dp_out.dest_reg_from = dp_dec.dest_reg_from;
        dbus_re   = is_load;
        dbus_we   = is_store;
        branching = is_branch;
        if (!stall) begin
          increment_pc = 1'b1;
          load_rd      = !is_jump && (dp_dec.dest_reg_from != DestNone);
          state_d      = is_jump ? StJump : StFetch;
        end
      end
      StJump: begin
        dp_out.dest_reg_from = DestPc;
        load_rd              = 1'b1;
        load_pc              = 1'b1;
        state_d              = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Reset aborts everything: no strobe may leak out while rst is low.
    if (!rst) begin
      fetch_next_instruction = 1'b0;
      load_ir                = 1'b0;
      increment_pc           = 1'b0;
      load_pc                = 1'b0;
      dbus_we                = 1'b0;
      dbus_re                = 1'b0;
      load_rd                = 1'b0;
      branching              = 1'b0;
    end
  end

  assign data_path           = dp_out;
  assign alu_mode            = mode_dec;
  assign invert_logic_result = inv_dec;

  assign take    = (alu_out != '0) ^ inv_dec;
  assign pc_step = (take && branching) ? imm : instruction_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      force_ack_q <= force_req;
    end else begin
      force_ack_q <= force_req;
      state_q     <= (force_req != force_ack_q) ? StExecute : state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (load_pc) begin
      pc_q <= is_jalr ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
    end else if (increment_pc) begin
      pc_q <= pc_q + pc_step;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: vector table for single-cycle decode/ALU/branch behaviour,
// plus hand-written sequences for stalls, jumps, debug hold and reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        stall, debug_wait;
  logic [31:0] alu_in_a, alu_in_b, imm, instruction_len;
  logic [3:0]  data_path, alu_mode;
  logic        invert_logic_result, fetch_next_instruction, load_ir, increment_pc, load_pc;
  logic        dbus_we, dbus_re, load_rd, branching;
  logic [31:0] alu_out, pc_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] pc_model;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .opcode                 (opcode),
    .f3                     (f3),
    .f7                     (f7),
    .stall                  (stall),
    .debug_wait             (debug_wait),
    .alu_in_a               (alu_in_a),
    .alu_in_b               (alu_in_b),
    .imm                    (imm),
    .instruction_len        (instruction_len),
    .data_path              (data_path),
    .alu_mode               (alu_mode),
    .invert_logic_result    (invert_logic_result),
    .fetch_next_instruction (fetch_next_instruction),
    .load_ir                (load_ir),
    .increment_pc           (increment_pc),
    .load_pc                (load_pc),
    .dbus_we                (dbus_we),
    .dbus_re                (dbus_re),
    .load_rd                (load_rd),
    .branching              (branching),
    .alu_out                (alu_out),
    .pc_out                 (pc_out)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm;
    logic [3:0]  dp, mode;
    logic        inv, br, rd, we, re;
    logic [31:0] alu;
    logic        take;
  } vec_t;

  vec_t vecs[16];

  // Packed control view: {data_path, mode, inv, br, rd, inc, we, re, load_pc, fetch, load_ir}.
  function automatic logic [16:0] pack(input logic [3:0] dp, input logic [3:0] m,
      input logic inv, input logic br, input logic rd, input logic inc, input logic we,
      input logic re, input logic lpc, input logic fet, input logic lir);
    return {dp, m, inv, br, rd, inc, we, re, lpc, fet, lir};
  endfunction

  function automatic logic [16:0] ctrl_act();
    return {data_path, alu_mode, invert_logic_result, branching, load_rd, increment_pc,
            dbus_we, dbus_re, load_pc, fetch_next_instruction, load_ir};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               op           f3      f7     a             b             imm
    //               dp     mode   inv br rd we re alu           take
    vecs[0]  = '{7'b0010011, 3'b000, 7'h00, 32'd5,        32'hFFFFFFF9, 32'd0,
                 4'b0101, 4'd0, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 0};
    vecs[1]  = '{7'b0110011, 3'b000, 7'h20, 32'd3,        32'd5,        32'd0,
                 4'b0001, 4'd1, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 0};
    vecs[2]  = '{7'b1100011, 3'b000, 7'h00, 32'd9,        32'd9,        32'd16,
                 4'b0000, 4'd1, 1, 1, 0, 0, 0, 32'd0,        1};
    vecs[3]  = '{7'b1100011, 3'b000, 7'h00, 32'd9,        32'd3,        32'd16,
                 4'b0000, 4'd1, 1, 1, 0, 0, 0, 32'd6,        0};
    vecs[4]  = '{7'b1100011, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd8,
                 4'b0000, 4'd3, 0, 1, 0, 0, 0, 32'd1,        1};
    vecs[5]  = '{7'b1100011, 3'b111, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd8,
                 4'b0000, 4'd4, 1, 1, 0, 0, 0, 32'd1,        0};
    vecs[6]  = '{7'b0010011, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'd0,
                 4'b0101, 4'd7, 0, 0, 1, 0, 0, 32'hF8000000, 0};
    vecs[7]  = '{7'b0110011, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,
                 4'b0001, 4'd4, 0, 0, 1, 0, 0, 32'd1,        0};
    vecs[8]  = '{7'b0010111, 3'b000, 7'h00, 32'h30,       32'h1000,     32'd0,
                 4'b1101, 4'd0, 0, 0, 1, 0, 0, 32'h1030,     0};
    vecs[9]  = '{7'b0100011, 3'b010, 7'h00, 32'h100,      32'd8,        32'd0,
                 4'b0100, 4'd0, 0, 0, 0, 1, 0, 32'h108,      0};
    vecs[10] = '{7'b0110011, 3'b001, 7'h00, 32'd1,        32'h21,       32'd0,
                 4'b0001, 4'd2, 0, 0, 1, 0, 0, 32'd2,        0};
    vecs[11] = '{7'b0110011, 3'b100, 7'h00, 32'hF0,       32'hFF,       32'd0,
                 4'b0001, 4'd5, 0, 0, 1, 0, 0, 32'h0F,       0};
    vecs[12] = '{7'b1111111, 3'b000, 7'h00, 32'd1,        32'd2,        32'd0,
                 4'b0000, 4'd0, 0, 0, 0, 0, 0, 32'd3,        0};
    vecs[13] = '{7'b0110011, 3'b111, 7'h00, 32'hF0F0,     32'hFF00,     32'd0,
                 4'b0001, 4'd9, 0, 0, 1, 0, 0, 32'hF000,     0};
    vecs[14] = '{7'b0110111, 3'b000, 7'h00, 32'd0,        32'h12345000, 32'd0,
                 4'b0101, 4'd0, 0, 0, 1, 0, 0, 32'h12345000, 0};
    vecs[15] = '{7'b1100011, 3'b001, 7'h00, 32'd5,        32'd5,        32'd12,
                 4'b0000, 4'd1, 0, 1, 0, 0, 0, 32'd0,        0};

    rst = 1'b0; stall = 1'b1; debug_wait = 1'b0;
    opcode = 7'h00; f3 = 3'h0; f7 = 7'h00;
    alu_in_a = '0; alu_in_b = '0; imm = '0; instruction_len = 32'd4;
    pc_model = 32'h0;

    // Reset: pc at RESET_PC, no strobes while rst is low.
    #3;
    check("reset_pc", pc_out, 32'h0);
    check("reset_ctrl", 32'(ctrl_act()), 32'(pack(4'b0000, 4'd0, 0,0,0,0,0,0,0,0,0)));
    tick(); tick();
    rst = 1'b1;
    #1;
    check("fetch_after_reset", 32'(ctrl_act()), 32'(pack(4'b0000, 4'd0, 0,0,0,0,0,0,0,1,1)));
    tick();
    check("fetch_hold_stall", 32'(ctrl_act()), 32'(pack(4'b0000, 4'd0, 0,0,0,0,0,0,0,1,1)));
    stall = 1'b0; debug_wait = 1'b1;
    tick(); tick();
    check("fetch_hold_debug", 32'(ctrl_act()), 32'(pack(4'b0000, 4'd0, 0,0,0,0,0,0,0,1,1)));
    check("pc_hold_debug", pc_out, 32'h0);
    debug_wait = 1'b0;

    foreach (vecs[i]) begin
      tick();  // FETCH -> EXECUTE
      opcode = vecs[i].op; f3 = vecs[i].f3; f7 = vecs[i].f7;
      alu_in_a = vecs[i].a; alu_in_b = vecs[i].b; imm = vecs[i].imm;
      #1;
      check($sformatf("v%0d_ctrl", i), 32'(ctrl_act()),
            32'(pack(vecs[i].dp, vecs[i].mode, vecs[i].inv, vecs[i].br, vecs[i].rd, 1'b1,
                     vecs[i].we, vecs[i].re, 1'b0, 1'b0, 1'b0)));
      check($sformatf("v%0d_alu", i), alu_out, vecs[i].alu);
      tick();  // EXECUTE -> FETCH
      pc_model = vecs[i].take ? pc_model + vecs[i].imm : pc_model + 32'd4;
      check($sformatf("v%0d_pc", i), pc_out, pc_model);
    end

    // LOAD stalled for three cycles.
    tick();
    opcode = 7'b0000011; f3 = 3'b010; f7 = 7'h00;
    alu_in_a = 32'h200; alu_in_b = 32'd4; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("load_stall%0d", c), 32'(ctrl_act()),
            32'(pack(4'b0110, 4'd0, 0,0,0,0,0,1,0,0,0)));
      tick();
    end
    check("load_stall_pc", pc_out, pc_model);
    stall = 1'b0;
    #1;
    check("load_done", 32'(ctrl_act()), 32'(pack(4'b0110, 4'd0, 0,0,1,1,0,1,0,0,0)));
    check("load_addr", alu_out, 32'h204);
    tick();
    pc_model = pc_model + 32'd4;
    check("load_pc", pc_out, pc_model);
    check("load_back_fetch", 32'(ctrl_act()), 32'(pack(4'b0100, 4'd0, 0,0,0,0,0,0,0,1,1)));

    // JALR: target 0x101 lands on 0x100.
    tick();
    opcode = 7'b1100111; f3 = 3'b000; alu_in_a = 32'hFF; alu_in_b = 32'd2; imm = 32'd2;
    #1;
    check("jalr_exec", 32'(ctrl_act()), 32'(pack(4'b0100, 4'd0, 0,0,0,1,0,0,0,0,0)));
    tick();
    pc_model = pc_model + 32'd4;
    check("jalr_link_pc", pc_out, pc_model);
    check("jalr_jump", 32'(ctrl_act()), 32'(pack(4'b0111, 4'd0, 0,0,1,0,0,0,1,0,0)));
    tick();
    check("jalr_target", pc_out, 32'h100);

    // JAL at 0x100 with offset 0x20.
    tick();
    opcode = 7'b1101111; alu_in_a = 32'h100; alu_in_b = 32'h20; imm = 32'h20;
    #1;
    check("jal_exec", 32'(ctrl_act()), 32'(pack(4'b1100, 4'd0, 0,0,0,1,0,0,0,0,0)));
    tick();
    check("jal_link_pc", pc_out, 32'h104);
    check("jal_jump", 32'(ctrl_act()), 32'(pack(4'b1111, 4'd0, 0,0,1,0,0,0,1,0,0)));
    check("jal_alu", alu_out, 32'h120);
    tick();
    check("jal_target", pc_out, 32'h120);
    check("jal_back_fetch", 32'(ctrl_act()), 32'(pack(4'b1100, 4'd0, 0,0,0,0,0,0,0,1,1)));

    // Forced EXECUTE while debug_wait would otherwise hold FETCH.
    debug_wait = 1'b1; opcode = 7'h7F; alu_in_a = 32'd1; alu_in_b = 32'd2;
    dut.set_execute();
    tick();
    check("forced_exec", 32'(ctrl_act()), 32'(pack(4'b0000, 4'd0, 0,0,0,1,0,0,0,0,0)));
    tick();
    check("forced_exec_pc", pc_out, 32'h124);
    debug_wait = 1'b0;

    // Reset in the middle of a stalled LOAD.
    tick();
    opcode = 7'b0000011; alu_in_a = 32'h200; alu_in_b = 32'd4; stall = 1'b1;
    #1;
    check("pre_reset_load", 32'(ctrl_act()), 32'(pack(4'b0110, 4'd0, 0,0,0,0,0,1,0,0,0)));
    rst = 1'b0;
    #1;
    check("midreset_ctrl", 32'(ctrl_act()), 32'(pack(4'b0100, 4'd0, 0,0,0,0,0,0,0,0,0)));
    check("midreset_pc", pc_out, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("post_reset_fetch", 32'(ctrl_act()), 32'(pack(4'b0100, 4'd0, 0,0,0,0,0,0,0,1,1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
